// File: rtl/volume_pkg.sv
// Shared types and the saturating step helper for the multi-channel volume block.
package volume_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DN
  } dir_t;

  // One volume step that never goes below 0 or above ceil_val.
  function automatic int unsigned sat_step(input int unsigned value,
                                           input dir_t        dir,
                                           input int unsigned ceil_val);
    int unsigned res;
    res = value;
    case (dir)
      UP:      if (value < ceil_val) res = value + 1;
      DN:      if (value > 0) res = value - 1;
      default: res = value;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/repeat_engine.sv
// Auto-repeat engine: turns a held up/down button into step strobes paced by tick.
//
//   state  | meaning
//   IDLE   | no button held, waiting for a press
//   DELAY  | button held, counting ticks until auto-repeat starts
//   REPEAT | auto-repeating, one step every REPEAT_RATE ticks
module repeat_engine
  import volume_pkg::*;
#(
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2,
  parameter int SW           = 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          tick,
  input  logic          up,
  input  logic          down,
  input  logic [SW-1:0] sel,
  output logic          step,
  output dir_t          step_dir,
  output logic [SW-1:0] step_chan
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  rpt_state_t    state;
  dir_t          dir;
  logic [SW-1:0] chan;
  logic [CW-1:0] count;

  dir_t req;
  logic new_press;
  logic at_limit;
  logic tc;

  // Button request; up wins when both are held.
  always_comb begin
    if (up)        req = UP;
    else if (down) req = DN;
    else           req = NONE;
  end

  // A press, a direction change or a channel change all restart the sequence with an immediate step.
  always_comb begin
    new_press = (req != NONE) && ((state == IDLE) || (req != dir) || (sel != chan));
    if (state == DELAY) at_limit = (count == CW'(REPEAT_DELAY - 1));
    else                at_limit = (count == CW'(REPEAT_RATE - 1));
    tc        = tick && at_limit && (state != IDLE);
    step      = new_press || ((req != NONE) && tc);
    step_dir  = new_press ? req : dir;
    step_chan = new_press ? sel : chan;
  end

  // State, latched direction/channel and tick counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      dir   <= NONE;
      chan  <= '0;
      count <= '0;
    end else if (req == NONE) begin
      state <= IDLE;
      count <= '0;
    end else if (new_press) begin
      state <= DELAY;
      dir   <= req;
      chan  <= sel;
      count <= '0;
    end else if (tc) begin
      state <= REPEAT;
      count <= '0;
    end else if (tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/volume_ctrl_multi.sv
// Multi-channel saturating volume with mode ceiling, per-channel mute and auto-repeat.
module volume_ctrl_multi
  import volume_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int NCH          = 2,
  parameter int MODE_MAX     = 9,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2,
  localparam int SW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       tick,
  input  logic                       up,
  input  logic                       down,
  input  logic                       mode,
  input  logic [SW-1:0]              sel,
  input  logic                       mute_tgl,
  output logic [NCH-1:0][WIDTH-1:0]  volume,
  output logic [NCH-1:0]             muted,
  output logic [NCH-1:0][WIDTH-1:0]  level
);

  localparam int unsigned FULL = (2 ** WIDTH) - 1;
  localparam int unsigned MM   = MODE_MAX;

  logic          step;
  dir_t          step_dir;
  logic [SW-1:0] step_chan;
  int unsigned   ceil_val;

  repeat_engine #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .SW          (SW)
  ) u_repeat (
    .clk      (clk),
    .n_reset  (n_reset),
    .tick     (tick),
    .up       (up),
    .down     (down),
    .sel      (sel),
    .step     (step),
    .step_dir (step_dir),
    .step_chan(step_chan)
  );

  assign ceil_val = mode ? MM : FULL;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             hit;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] vol_q;
    logic             mute_q;

    // Clamp to the reduced ceiling first so a same-cycle step starts from the clamped value.
    always_comb begin
      hit  = step && (step_chan == SW'(i));
      base = (mode && (32'(vol_q) > MM)) ? WIDTH'(MM) : vol_q;
      nxt  = hit ? WIDTH'(sat_step(32'(base), step_dir, ceil_val)) : base;
    end

    // Volume and mute registers for this channel.
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        vol_q  <= '0;
        mute_q <= 1'b0;
      end else begin
        vol_q <= nxt;
        if (mute_tgl && (sel == SW'(i))) mute_q <= ~mute_q;
      end
    end

    assign volume[i] = vol_q;
    assign muted[i]  = mute_q;
    assign level[i]  = mute_q ? '0 : vol_q;
  end

endmodule

// File: tb/tb_volume_ctrl_multi.sv
// Bench for volume_ctrl_multi: directed stimulus, behavioural model checked every cycle.
module tb_volume_ctrl_multi;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int MMAX  = 9;
  localparam int RD    = 4;
  localparam int RR    = 2;

  logic clk, n_reset, tick, up, down, mode, mute_tgl;
  logic [0:0] sel;
  logic [NCH-1:0][WIDTH-1:0] volume;
  logic [NCH-1:0][WIDTH-1:0] level;
  logic [NCH-1:0]            muted;

  int checks = 0;
  int errors = 0;

  int m_vol[NCH];
  int m_mute[NCH];
  int m_hold, m_dir, m_chan, m_nt;

  volume_ctrl_multi #(
    .WIDTH(WIDTH), .NCH(NCH), .MODE_MAX(MMAX),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .n_reset(n_reset), .tick(tick), .up(up), .down(down),
    .mode(mode), .sel(sel), .mute_tgl(mute_tgl),
    .volume(volume), .muted(muted), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a step on press/change, then at ticks RD, RD+RR, RD+2RR... counted since the press.
  always @(posedge clk or negedge n_reset) begin : model
    int req, sdir, schan, ceil_v;
    bit stp;
    if (!n_reset) begin
      m_hold = 0; m_dir = 0; m_chan = 0; m_nt = 0;
      for (int c = 0; c < NCH; c++) begin m_vol[c] = 0; m_mute[c] = 0; end
    end else begin
      req = up ? 1 : (down ? 2 : 0);
      stp = 0; sdir = req; schan = int'(sel);
      if (req == 0) m_hold = 0;
      else if (!m_hold || req != m_dir || int'(sel) != m_chan) begin
        stp = 1; m_hold = 1; m_dir = req; m_chan = int'(sel); m_nt = 0;
      end else if (tick) begin
        m_nt++;
        if (m_nt >= RD && ((m_nt - RD) % RR) == 0) stp = 1;
      end
      ceil_v = mode ? MMAX : (2 ** WIDTH) - 1;
      for (int c = 0; c < NCH; c++) begin
        if (mode && m_vol[c] > MMAX) m_vol[c] = MMAX;
        if (stp && schan == c) begin
          if (sdir == 1 && m_vol[c] < ceil_v) m_vol[c] = m_vol[c] + 1;
          if (sdir == 2 && m_vol[c] > 0) m_vol[c] = m_vol[c] - 1;
        end
        if (mute_tgl && int'(sel) == c) m_mute[c] = m_mute[c] ? 0 : 1;
      end
    end
  end

  // Compare every channel against the model on each falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (volume[c] !== WIDTH'(m_vol[c])) begin
        errors++;
        $display("FAIL volume[%0d] t=%0t got %0d exp %0d", c, $time, volume[c], m_vol[c]);
      end
      checks++;
      if (muted[c] !== 1'(m_mute[c])) begin
        errors++;
        $display("FAIL muted[%0d] t=%0t got %0d exp %0d", c, $time, muted[c], m_mute[c]);
      end
      checks++;
      if (level[c] !== WIDTH'(m_mute[c] ? 0 : m_vol[c])) begin
        errors++;
        $display("FAIL level[%0d] t=%0t got %0d exp %0d", c, $time, level[c],
                 m_mute[c] ? 0 : m_vol[c]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Four idle clocks then a one-cycle tick.
  task automatic tick_wait();
    cyc(4); tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  task automatic pulse_up();
    up = 1'b1; cyc(1); up = 1'b0; cyc(1);
  endtask

  task automatic pulse_down();
    down = 1'b1; cyc(1); down = 1'b0; cyc(1);
  endtask

  initial begin
    tick = 0; up = 0; down = 0; mode = 0; mute_tgl = 0; sel = 0;
    n_reset = 1'b1;
    #2 n_reset = 1'b0;
    cyc(2);
    chk("rst_vol0", int'(volume[0]), 0);
    chk("rst_vol1", int'(volume[1]), 0);
    chk("rst_muted", int'(muted), 0);
    n_reset = 1'b1;
    cyc(1);

    // Single press
    up = 1; cyc(1);
    chk("s1_vol0", int'(volume[0]), 1);
    chk("s1_vol1", int'(volume[1]), 0);
    up = 0; cyc(2);
    chk("s1_hold", int'(volume[0]), 1);

    // Held up with auto-repeat up to saturation
    n_reset = 0; cyc(1); n_reset = 1; cyc(1);
    up = 1; cyc(1);
    chk("s2_press", int'(volume[0]), 1);
    for (int t = 1; t <= 40; t++) begin
      tick_wait();
      if (t == 3) chk("s2_t3", int'(volume[0]), 1);
      if (t == 4) chk("s2_t4", int'(volume[0]), 2);
      if (t == 5) chk("s2_t5", int'(volume[0]), 2);
      if (t == 6) chk("s2_t6", int'(volume[0]), 3);
      if (t == 30) chk("s2_t30", int'(volume[0]), 15);
    end
    chk("s2_sat", int'(volume[0]), 15);
    up = 0; cyc(1);

    // Mode clamp on held up, then down press on a clamped channel
    sel = 1;
    repeat (13) pulse_up();
    chk("s3_13", int'(volume[1]), 13);
    up = 1; cyc(1);
    chk("s3_14", int'(volume[1]), 14);
    mode = 1; cyc(1);
    chk("s3_clamp1", int'(volume[1]), 9);
    chk("s3_clamp0", int'(volume[0]), 9);
    repeat (6) tick_wait();
    chk("s3_stay9", int'(volume[1]), 9);
    up = 0; mode = 0; cyc(1);
    repeat (4) pulse_up();
    chk("s3_back13", int'(volume[1]), 13);
    down = 1; mode = 1; cyc(1);
    chk("s3_dn8", int'(volume[1]), 8);
    down = 0; mode = 0; cyc(1);

    // Direction switch without release restarts the delay
    sel = 0;
    repeat (4) pulse_down();
    chk("s4_5", int'(volume[0]), 5);
    up = 1; cyc(1);
    chk("s4_up6", int'(volume[0]), 6);
    up = 0; down = 1; cyc(1);
    chk("s4_sw5", int'(volume[0]), 5);
    repeat (3) tick_wait();
    chk("s4_wait", int'(volume[0]), 5);
    tick_wait();
    chk("s4_rep4", int'(volume[0]), 4);
    down = 0; cyc(1);

    // Mute
    sel = 1;
    pulse_down();
    chk("s5_7", int'(volume[1]), 7);
    mute_tgl = 1; cyc(1); mute_tgl = 0;
    chk("s5_muted", int'(muted[1]), 1);
    chk("s5_lvl0", int'(level[1]), 0);
    chk("s5_vol7", int'(volume[1]), 7);
    pulse_down();
    chk("s5_vol6", int'(volume[1]), 6);
    chk("s5_lvl_m", int'(level[1]), 0);
    mute_tgl = 1; cyc(1); mute_tgl = 0;
    chk("s5_lvl6", int'(level[1]), 6);
    sel = 0;
    mute_tgl = 1; up = 1; cyc(1); mute_tgl = 0; up = 0; cyc(1);
    chk("s5_both_vol", int'(volume[0]), 5);
    chk("s5_both_mute", int'(muted[0]), 1);
    chk("s5_both_lvl", int'(level[0]), 0);
    mute_tgl = 1; cyc(1); mute_tgl = 0; cyc(1);

    // Asynchronous reset in REPEAT with the button still held
    up = 1; cyc(1);
    chk("s6_press", int'(volume[0]), 6);
    repeat (10) tick_wait();
    chk("s6_10", int'(volume[0]), 10);
    tick_wait();
    #2 n_reset = 0;
    #1;
    chk("s6_rst_vol0", int'(volume[0]), 0);
    chk("s6_rst_vol1", int'(volume[1]), 0);
    chk("s6_rst_lvl0", int'(level[0]), 0);
    chk("s6_rst_muted", int'(muted), 0);
    cyc(2);
    n_reset = 1;
    cyc(1);
    chk("s6_after", int'(volume[0]), 1);
    up = 0; cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
